io_sync_filter_3v: RTL and testbench

- Parametrised, multi-channel input-conditioning block for the 3V pad-side logic domain.
- Successor to the single-bit buffer, inverter and tie stand-ins: it adds per-channel selectable inversion and per-channel force-to-constant (tie) control.
- Each asynchronous input passes through a synchroniser chain and a programmable glitch filter.
- Outputs are registered levels plus single-cycle rise/fall pulses, feeding the core's GPIO/IRQ logic.

---
 rtl/io_sync_filter_3v.sv | 113 +++++++++++
 tb/tb_io_sync_filter_3v.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_sync_filter_3v.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : io_sync_filter_3v
// Purpose  : Multi-channel pad-input conditioner for the 3V domain. Each
//            channel has a synchroniser chain, optional inversion, a
//            programmable glitch filter and a force-to-constant (tie)
//            override. It produces a registered level plus one-cycle
//            rise/fall pulses.
// Ports    : clk        - single clock
//            resetn     - asynchronous active-low reset
//            din        - raw asynchronous pad inputs          [NCH]
//            invert     - 1 = invert synchronised value        [NCH]
//            filt_en    - glitch filter enable                 [NCH]
//            filt_len   - shared filter length L in cycles     [CNT_W]
//            force_en   - 1 = ignore din, drive force_val      [NCH]
//            force_val  - tie level used under force_en        [NCH]
//            dout       - conditioned registered level         [NCH]
//            rise/fall  - one-cycle pulses on dout edges       [NCH]
//            busy       - filter counter nonzero               [NCH]
// Revision : 1.0 - initial release
// ============================================================================
module io_sync_filter_3v #(
    parameter int             NCH         = 4,
    parameter int             SYNC_STAGES = 2,
    parameter int             CNT_W       = 4,
    parameter logic [NCH-1:0] RESET_VAL   = {NCH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NCH-1:0]   din,
    input  logic [NCH-1:0]   invert,
    input  logic [NCH-1:0]   filt_en,
    input  logic [CNT_W-1:0] filt_len,
    input  logic [NCH-1:0]   force_en,
    input  logic [NCH-1:0]   force_val,
    output logic [NCH-1:0]   dout,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall,
    output logic [NCH-1:0]   busy
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    // A single-stage chain is not a synchroniser; refuse to elaborate.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("io_sync_filter_3v: SYNC_STAGES must be at least 2");
    end

    // Shared length decode. w_len_m1 is only consulted when L >= 2, so the
    // wrap at L = 0 is never observed.
    logic             w_len_short;
    logic [CNT_W-1:0] w_len_m1;

    assign w_len_short = (filt_len <= c_one);
    assign w_len_m1    = filt_len - c_one;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_dout;
        logic                   r_rise;
        logic                   r_fall;
        logic [CNT_W-1:0]       r_cnt;
        logic                   w_s;
        logic                   w_next_dout;
        logic [CNT_W-1:0]       w_next_cnt;

        assign w_s = r_sync[SYNC_STAGES-1] ^ invert[gi];

        // Priority: force, filter bypass, glitch reject, commit, count.
        // The ">=" lets a shortened filt_len commit on the next mismatching
        // cycle; since it fires before the counter can exceed L-1 the
        // counter never wraps.
        always_comb begin
            w_next_dout = r_dout;
            w_next_cnt  = '0;
            if (force_en[gi]) begin
                w_next_dout = force_val[gi];
            end else if (!filt_en[gi] || w_len_short) begin
                w_next_dout = w_s;
            end else if (w_s == r_dout) begin
                w_next_cnt = '0;
            end else if (r_cnt >= w_len_m1) begin
                w_next_dout = w_s;
            end else begin
                w_next_cnt = r_cnt + c_one;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_sync <= {SYNC_STAGES{RESET_VAL[gi]}};
                r_dout <= RESET_VAL[gi];
                r_cnt  <= '0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], din[gi]};
                r_dout <= w_next_dout;
                r_cnt  <= w_next_cnt;
                r_rise <= ~r_dout & w_next_dout;
                r_fall <= r_dout & ~w_next_dout;
            end
        end

        assign dout[gi] = r_dout;
        assign rise[gi] = r_rise;
        assign fall[gi] = r_fall;
        assign busy[gi] = (r_cnt != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_io_sync_filter_3v.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_io_sync_filter_3v
// Purpose  : Self-checking bench for io_sync_filter_3v. Directed scenarios
//            followed by randomised stimulus compared against a behavioural
//            model built from a din sample history and per-channel counts
//            of consecutive mismatching edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_sync_filter_3v;

    localparam int             NCH         = 4;
    localparam int             SYNC_STAGES = 2;
    localparam int             CNT_W       = 4;
    localparam logic [NCH-1:0] RESET_VAL   = 4'b1010;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic [NCH-1:0]   din = RESET_VAL;
    logic [NCH-1:0]   invert = '0;
    logic [NCH-1:0]   filt_en = '0;
    logic [CNT_W-1:0] filt_len = '0;
    logic [NCH-1:0]   force_en = '0;
    logic [NCH-1:0]   force_val = '0;
    logic [NCH-1:0]   dout, rise, fall, busy;

    int n_checks = 0;
    int n_pass   = 0;

    io_sync_filter_3v #(
        .NCH(NCH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .RESET_VAL(RESET_VAL)
    ) dut (
        .clk(clk), .resetn(resetn), .din(din), .invert(invert),
        .filt_en(filt_en), .filt_len(filt_len), .force_en(force_en),
        .force_val(force_val), .dout(dout), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. m_hist[j] is the din sample taken j+1 edges ago, so
    // the value reaching the filter at an edge is the sample SYNC_STAGES
    // edges old. m_run counts consecutive edges on which the synchronised
    // value disagreed with dout; a change is accepted once that run spans
    // L edges.
    // ------------------------------------------------------------------
    logic [NCH-1:0] m_hist[$];
    logic [NCH-1:0] m_dout, m_rise, m_fall, m_busy;
    logic [NCH-1:0] m_s, m_nd;
    int             m_run[NCH];
    int             m_len;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hist = {};
            for (int j = 0; j < SYNC_STAGES; j++) m_hist.push_back(RESET_VAL);
            m_dout = RESET_VAL;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NCH; c++) m_run[c] = 0;
        end else begin
            m_s   = m_hist[SYNC_STAGES-1] ^ invert;
            m_nd  = m_dout;
            m_len = int'(filt_len);
            for (int c = 0; c < NCH; c++) begin
                if (force_en[c]) begin
                    m_nd[c] = force_val[c];
                    m_run[c] = 0;
                end else if (!filt_en[c] || m_len <= 1) begin
                    m_nd[c] = m_s[c];
                    m_run[c] = 0;
                end else if (m_s[c] == m_dout[c]) begin
                    m_run[c] = 0;
                end else if (m_run[c] + 1 >= m_len) begin
                    m_nd[c] = m_s[c];
                    m_run[c] = 0;
                end else begin
                    m_run[c] = m_run[c] + 1;
                end
            end
            m_rise = ~m_dout & m_nd;
            m_fall = m_dout & ~m_nd;
            m_dout = m_nd;
            m_hist.push_front(din);
            void'(m_hist.pop_back());
        end
        for (int c = 0; c < NCH; c++) m_busy[c] = (m_run[c] != 0);
    end

    // Advance to the n-th following falling edge (outputs are stable there).
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #0.5;
        n_checks++; if (dout !== RESET_VAL) $display("FAIL reset_dout: got %b want %b", dout, RESET_VAL); else n_pass++;
        n_checks++; if (rise !== 4'b0) $display("FAIL reset_rise: got %b want 0000", rise); else n_pass++;
        n_checks++; if (fall !== 4'b0) $display("FAIL reset_fall: got %b want 0000", fall); else n_pass++;
        n_checks++; if (busy !== 4'b0) $display("FAIL reset_busy: got %b want 0000", busy); else n_pass++;
        tick(2);
        resetn = 1'b1;
        begin
            int pulses = 0;
            for (int k = 0; k < 6; k++) begin
                tick(1);
                pulses += $countones(rise | fall);
            end
            n_checks++; if (pulses != 0) $display("FAIL reset_quiet: got %0d pulses want 0", pulses); else n_pass++;
        end
        n_checks++; if (dout !== RESET_VAL) $display("FAIL reset_hold: got %b want %b", dout, RESET_VAL); else n_pass++;
    endtask

    task automatic test_passthrough();
        din[0] = 1'b1;
        tick(2);
        n_checks++; if (dout[0] !== 1'b0) $display("FAIL pass_early: got %b want 0", dout[0]); else n_pass++;
        tick(1);
        n_checks++; if (dout[0] !== 1'b1) $display("FAIL pass_dout: got %b want 1", dout[0]); else n_pass++;
        n_checks++; if (rise[0] !== 1'b1) $display("FAIL pass_rise: got %b want 1", rise[0]); else n_pass++;
        tick(1);
        n_checks++; if (rise[0] !== 1'b0) $display("FAIL pass_rise_end: got %b want 0", rise[0]); else n_pass++;
    endtask

    task automatic test_filter();
        int busy_seen = 0;
        int rises = 0;
        int bad = 0;
        din[1] = 1'b0;
        tick(4);
        n_checks++; if (dout[1] !== 1'b0) $display("FAIL filt_setup: got %b want 0", dout[1]); else n_pass++;
        filt_en[1] = 1'b1;
        filt_len   = 4'd5;
        din[1]     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) din[1] = 1'b0;
            tick(1);
            if (busy[1] === 1'b1) busy_seen++;
            if (rise[1] === 1'b1) rises++;
            if (dout[1] !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL filt_glitch_dout: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (rises != 0) $display("FAIL filt_glitch_rise: got %0d want 0", rises); else n_pass++;
        n_checks++; if (busy_seen == 0) $display("FAIL filt_busy_seen: got %0d want >0", busy_seen); else n_pass++;
        n_checks++; if (busy[1] !== 1'b0) $display("FAIL filt_busy_clear: got %b want 0", busy[1]); else n_pass++;
        din[1] = 1'b1;
        tick(6);
        n_checks++; if (dout[1] !== 1'b0) $display("FAIL filt_pre_commit: got %b want 0", dout[1]); else n_pass++;
        tick(1);
        n_checks++; if (dout[1] !== 1'b1) $display("FAIL filt_commit: got %b want 1", dout[1]); else n_pass++;
        n_checks++; if (rise[1] !== 1'b1) $display("FAIL filt_rise: got %b want 1", rise[1]); else n_pass++;
        tick(1);
        n_checks++; if (rise[1] !== 1'b0) $display("FAIL filt_rise_end: got %b want 0", rise[1]); else n_pass++;
    endtask

    task automatic test_invert();
        int rises = 0;
        int falls = 0;
        din[2]    = 1'b0;
        invert[2] = 1'b1;
        resetn    = 1'b0;
        #1 resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            rises += int'(rise[2]);
            falls += int'(fall[2]);
        end
        n_checks++; if (rises != 1 || falls != 0) $display("FAIL inv_release: got rise=%0d fall=%0d want 1/0", rises, falls); else n_pass++;
        n_checks++; if (dout[2] !== 1'b1) $display("FAIL inv_dout_hi: got %b want 1", dout[2]); else n_pass++;
        din[2] = 1'b1;
        rises = 0;
        falls = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            rises += int'(rise[2]);
            falls += int'(fall[2]);
        end
        n_checks++; if (rises != 0 || falls != 1) $display("FAIL inv_toggle: got rise=%0d fall=%0d want 0/1", rises, falls); else n_pass++;
        n_checks++; if (dout[2] !== 1'b0) $display("FAIL inv_dout_lo: got %b want 0", dout[2]); else n_pass++;
    endtask

    task automatic test_force();
        int rises = 0;
        int falls = 0;
        din[3] = 1'b0;
        tick(4);
        n_checks++; if (dout[3] !== 1'b0) $display("FAIL force_setup: got %b want 0", dout[3]); else n_pass++;
        force_en[3]  = 1'b1;
        force_val[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            din[3] = ~din[3];
            tick(1);
            rises += int'(rise[3]);
            falls += int'(fall[3]);
        end
        n_checks++; if (rises != 1 || falls != 0) $display("FAIL force_pulses: got rise=%0d fall=%0d want 1/0", rises, falls); else n_pass++;
        n_checks++; if (dout[3] !== 1'b1) $display("FAIL force_hold: got %b want 1", dout[3]); else n_pass++;
        din[3] = 1'b0;
        tick(3);
        force_en[3] = 1'b0;
        tick(1);
        n_checks++; if (dout[3] !== 1'b0) $display("FAIL force_release: got %b want 0", dout[3]); else n_pass++;
        n_checks++; if (fall[3] !== 1'b1) $display("FAIL force_release_fall: got %b want 1", fall[3]); else n_pass++;
    endtask

    task automatic test_len_reduce();
        filt_en[0] = 1'b1;
        filt_len   = 4'd10;
        din[0]     = 1'b0;
        tick(8);
        n_checks++; if (dout[0] !== 1'b1) $display("FAIL len_hold: got %b want 1", dout[0]); else n_pass++;
        n_checks++; if (busy[0] !== 1'b1) $display("FAIL len_busy: got %b want 1", busy[0]); else n_pass++;
        filt_len = 4'd3;
        tick(1);
        n_checks++; if (dout[0] !== 1'b0) $display("FAIL len_commit: got %b want 0", dout[0]); else n_pass++;
        n_checks++; if (fall[0] !== 1'b1) $display("FAIL len_fall: got %b want 1", fall[0]); else n_pass++;
        n_checks++; if (busy[0] !== 1'b0) $display("FAIL len_cnt_clear: got %b want 0", busy[0]); else n_pass++;
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        int bad = 0;
        invert   = '0;
        force_en = '0;
        filt_en  = '0;
        tick(4);
        filt_en  = 4'hF;
        filt_len = 4'd15;
        din      = ~m_dout;
        tick(6);
        n_checks++; if (busy !== 4'hF) $display("FAIL areset_pre_busy: got %b want 1111", busy); else n_pass++;
        #2;
        din    = RESET_VAL;
        resetn = 1'b0;
        #0.4;
        n_checks++; if (dout !== RESET_VAL) $display("FAIL areset_dout: got %b want %b", dout, RESET_VAL); else n_pass++;
        n_checks++; if ((rise | fall) !== 4'b0) $display("FAIL areset_pulses: got %b want 0000", rise | fall); else n_pass++;
        n_checks++; if (busy !== 4'b0) $display("FAIL areset_busy: got %b want 0000", busy); else n_pass++;
        #0.6 resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            pulses += $countones(rise | fall);
            if (dout !== RESET_VAL) bad++;
        end
        n_checks++; if (pulses != 0) $display("FAIL areset_quiet: got %0d pulses want 0", pulses); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL areset_hold: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            tick(1);
            n_checks++; if (dout !== m_dout) $display("FAIL rnd_dout @%0d: got %b want %b", k, dout, m_dout); else n_pass++;
            n_checks++; if (rise !== m_rise) $display("FAIL rnd_rise @%0d: got %b want %b", k, rise, m_rise); else n_pass++;
            n_checks++; if (fall !== m_fall) $display("FAIL rnd_fall @%0d: got %b want %b", k, fall, m_fall); else n_pass++;
            n_checks++; if (busy !== m_busy) $display("FAIL rnd_busy @%0d: got %b want %b", k, busy, m_busy); else n_pass++;
            if ($urandom_range(0, 2) == 0) din[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) invert[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0) filt_en[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) filt_len = CNT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) force_en[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) force_val = NCH'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 resetn = 1'b0;
                #1 resetn = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_filter();
        test_invert();
        test_force();
        test_len_reduce();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
